// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one combinational ALU between two requesters. One operation is in
//   flight at a time, and it moves through three states:
//     IDLE -> pick a requester, latch its op/operands, raise its ready
//     EXEC -> drive the latched op/operands to the ALU, capture the result
//     RESP -> present the registered result until the consumer takes it
//   When both requesters are valid in the same cycle, a one-bit priority
//   pointer breaks the tie. After each response the pointer moves to the
//   requester that was not served, so continuous contention alternates.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   reqN_valid_i / reqN_op_i   requester N has an operation / its opcode
//   reqN_a_i / reqN_b_i        requester N operands (WIDTH bits)
//   reqN_ready_o               requester N accepted this cycle (IDLE only)
//   alu_operation_o            opcode to shared ALU (zero outside EXEC)
//   alu_a_o / alu_b_o          operands to shared ALU (zero outside EXEC)
//   alu_result_i               combinational ALU result
//   rsp_valid_o / rsp_id_o     result available / owning requester
//   rsp_result_o               registered ALU result
//   rsp_ready_i                consumer accepts result (honoured in RESP only)
//   busy_o                     high whenever not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid_i,
  input  logic [3:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  output logic             req0_ready_o,

  input  logic             req1_valid_i,
  input  logic [3:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             req1_ready_o,

  output logic [3:0]       alu_operation_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,

  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_result_o,
  input  logic             rsp_ready_i,

  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic             prio_q,   prio_d;    // 0: requester 0 wins a tie
  logic             id_q,     id_d;      // requester owning the in-flight op
  logic [3:0]       op_q,     op_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             grant0;
  logic             grant1;

  // ---------------------------------------------------------------------------
  // Grant selection. The two grants are mutually exclusive by construction:
  // when both requesters are valid, the pointer alone decides. Requests are
  // not remembered, so a requester that drops valid simply loses its turn.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = req0_valid_i && (!req1_valid_i || !prio_q);
    grant1 = req1_valid_i && (!req0_valid_i ||  prio_q);
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset clears everything, including the operand and
  // result registers, so an operation interrupted by reset leaves no trace.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; outputs idle at zero.
    state_d         = state_q;
    prio_d          = prio_q;
    id_d            = id_q;
    op_d            = op_q;
    a_d             = a_q;
    b_d             = b_q;
    result_d        = result_q;

    req0_ready_o    = 1'b0;
    req1_ready_o    = 1'b0;
    alu_operation_o = '0;
    alu_a_o         = '0;
    alu_b_o         = '0;
    rsp_valid_o     = 1'b0;
    rsp_id_o        = 1'b0;
    rsp_result_o    = '0;
    busy_o          = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // Ready is combinational from valid, so it is masked by reset here
        // to keep every output at zero while reset is held.
        if (!reset && (grant0 || grant1)) begin
          req0_ready_o = grant0;
          req1_ready_o = grant1;
          id_d         = grant1;
          op_d         = grant1 ? req1_op_i : req0_op_i;
          a_d          = grant1 ? req1_a_i  : req0_a_i;
          b_d          = grant1 ? req1_b_i  : req0_b_i;
          state_d      = EXEC;
        end
      end

      EXEC: begin
        alu_operation_o = op_q;
        alu_a_o         = a_q;
        alu_b_o         = b_q;
        result_d        = alu_result_i;
        state_d         = RESP;
      end

      RESP: begin
        rsp_valid_o  = 1'b1;
        rsp_id_o     = id_q;
        rsp_result_o = result_q;
        if (rsp_ready_i) begin
          // Hand the next tie to whoever was not just served.
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
